// File: rtl/paddle_move_scheduler_if.sv
// Input-front-end to paddle-position bundle: request levels/pulses in, move strobe out.
interface paddle_move_scheduler_if;
    logic       enable;
    logic       tick;
    logic       rot_event;
    logic       rot_right;
    logic       btn_left;
    logic       btn_right;
    logic       move_event;
    logic       move_right;
    logic [4:0] speed;

    modport master (
        output enable, tick, rot_event, rot_right, btn_left, btn_right,
        input  move_event, move_right, speed
    );

    modport slave (
        input  enable, tick, rot_event, rot_right, btn_left, btn_right,
        output move_event, move_right, speed
    );
endinterface

// File: rtl/paddle_move_scheduler.sv
// Arbitrates rotary and auto-repeat button requests into one move strobe with accelerating speed.
// Latency: request in cycle N gives move_event in cycle N+1; all outputs registered.
// No backpressure: rotary wins collisions, the losing button move waits in a 1-deep pending slot.
module paddle_move_scheduler #(
    parameter int SPEED_MIN     = 2,
    parameter int SPEED_MAX     = 16,
    parameter int SPEED_STEP    = 2,
    parameter int ACCEL_WINDOW  = 4,
    parameter int REPEAT_DELAY  = 20,
    parameter int REPEAT_PERIOD = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    paddle_move_scheduler_if.slave  bus
);
    localparam int CMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int WW   = $clog2(ACCEL_WINDOW + 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} btn_state_t;

    btn_state_t    state;
    logic [CW-1:0] tick_cnt;
    logic [4:0]    btn_speed;
    logic          prev_held;
    logic          prev_dir;
    logic          pending;
    logic          pend_dir;
    logic [4:0]    pend_speed;
    logic          rot_valid;
    logic          rot_dir;
    logic [4:0]    rot_speed;
    logic [WW-1:0] win_cnt;

    logic          held;
    logic          hdir;
    logic          press;
    logic          btn_req;
    logic [4:0]    btn_req_speed;
    logic [4:0]    rot_new_speed;

    // 6-bit sum before clamping so SPEED_MAX near 31 cannot overflow
    function automatic logic [4:0] sat_add(input logic [4:0] s);
        logic [5:0] t;
        t = {1'b0, s} + 6'(SPEED_STEP);
        return (t > 6'(SPEED_MAX)) ? 5'(SPEED_MAX) : t[4:0];
    endfunction

    always_comb begin
        held          = bus.btn_left ^ bus.btn_right;
        hdir          = bus.btn_right;
        press         = held && (!prev_held || (prev_dir != hdir));
        rot_new_speed = (rot_valid && (rot_dir == bus.rot_right) && (win_cnt < WW'(ACCEL_WINDOW)))
                        ? sat_add(rot_speed) : 5'(SPEED_MIN);
        btn_req       = 1'b0;
        btn_req_speed = btn_speed;
        if (bus.enable && held) begin
            if (press) begin
                btn_req       = 1'b1;
                btn_req_speed = 5'(SPEED_MIN);
            end else if (bus.tick && state == DELAY && tick_cnt == CW'(REPEAT_DELAY - 1)) begin
                btn_req = 1'b1;
            end else if (bus.tick && state == REPEAT && tick_cnt == CW'(REPEAT_PERIOD - 1)) begin
                btn_req       = 1'b1;
                btn_req_speed = sat_add(btn_speed);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bus.move_event <= 1'b0;
            bus.move_right <= 1'b0;
            bus.speed      <= 5'(SPEED_MIN);
            state          <= IDLE;
            tick_cnt       <= '0;
            btn_speed      <= 5'(SPEED_MIN);
            prev_held      <= 1'b0;
            prev_dir       <= 1'b0;
            pending        <= 1'b0;
            pend_dir       <= 1'b0;
            pend_speed     <= 5'(SPEED_MIN);
            rot_valid      <= 1'b0;
            rot_dir        <= 1'b0;
            rot_speed      <= 5'(SPEED_MIN);
            win_cnt        <= '0;
        end else begin
            // Edge history tracks even while disabled, so a button held across enable is not a press
            prev_held      <= held;
            prev_dir       <= hdir;
            bus.move_event <= 1'b0;
            if (!bus.enable) begin
                state     <= IDLE;
                tick_cnt  <= '0;
                pending   <= 1'b0;
                rot_valid <= 1'b0;
                win_cnt   <= '0;
            end else begin
                if (bus.rot_event) begin
                    rot_valid <= 1'b1;
                    rot_dir   <= bus.rot_right;
                    rot_speed <= rot_new_speed;
                    win_cnt   <= '0;
                end else if (bus.tick && win_cnt < WW'(ACCEL_WINDOW)) begin
                    win_cnt <= win_cnt + WW'(1);
                end

                if (!held) begin
                    state    <= IDLE;
                    tick_cnt <= '0;
                end else if (press) begin
                    state     <= DELAY;
                    btn_speed <= 5'(SPEED_MIN);
                    tick_cnt  <= '0;
                end else if (bus.tick) begin
                    case (state)
                        DELAY: begin
                            if (tick_cnt == CW'(REPEAT_DELAY - 1)) begin
                                state    <= REPEAT;
                                tick_cnt <= '0;
                            end else begin
                                tick_cnt <= tick_cnt + CW'(1);
                            end
                        end
                        REPEAT: begin
                            if (tick_cnt == CW'(REPEAT_PERIOD - 1)) begin
                                btn_speed <= btn_req_speed;
                                tick_cnt  <= '0;
                            end else begin
                                tick_cnt <= tick_cnt + CW'(1);
                            end
                        end
                        default: ;
                    endcase
                end

                if (bus.rot_event) begin
                    bus.move_event <= 1'b1;
                    bus.move_right <= bus.rot_right;
                    bus.speed      <= rot_new_speed;
                    if (btn_req) begin
                        pending    <= 1'b1;
                        pend_dir   <= hdir;
                        pend_speed <= btn_req_speed;
                    end
                end else if (btn_req) begin
                    bus.move_event <= 1'b1;
                    bus.move_right <= hdir;
                    bus.speed      <= btn_req_speed;
                    pending        <= 1'b0;
                end else if (pending && held) begin
                    bus.move_event <= 1'b1;
                    bus.move_right <= pend_dir;
                    bus.speed      <= pend_speed;
                    pending        <= 1'b0;
                end

                if (!held) pending <= 1'b0;
            end
        end
    end
endmodule
